// File: rtl/iec_pkg.sv
// Shared IEC bus command-layer constants and the ATN-frame state type.
package iec_pkg;

  localparam logic [2:0] CMD_LISTEN   = 3'b001;
  localparam logic [2:0] CMD_TALK     = 3'b010;
  localparam logic [7:0] CMD_UNLISTEN = 8'h3F;
  localparam logic [7:0] CMD_UNTALK   = 8'h5F;
  localparam logic [3:0] SEC_DATA     = 4'h6;
  localparam logic [3:0] SEC_CLOSE    = 4'hE;
  localparam logic [3:0] SEC_OPEN     = 4'hF;

  typedef enum logic [1:0] {
    A_IDLE      = 2'd0,
    A_PRIMARY   = 2'd1,
    A_SECONDARY = 2'd2,
    A_IGNORE    = 2'd3
  } atn_state_e;

endpackage

// File: rtl/iec_cmd_decoder_if.sv
// Byte-receiver input, addressing status and listener-data handshake of the command decoder.
interface iec_cmd_decoder_if;

  logic       atn;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       listening;
  logic       talking;
  logic [3:0] sec_addr;
  logic       open_pulse;
  logic       close_pulse;
  logic       data_pulse;
  logic       talk_start;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       overflow;

  modport master (
    output atn, rx_byte, rx_ready, dout_ready,
    input  listening, talking, sec_addr, open_pulse, close_pulse, data_pulse,
           talk_start, dout, dout_valid, overflow
  );

  modport slave (
    input  atn, rx_byte, rx_ready, dout_ready,
    output listening, talking, sec_addr, open_pulse, close_pulse, data_pulse,
           talk_start, dout, dout_valid, overflow
  );

endinterface

// File: rtl/iec_sync_fifo.sv
// Single-clock FIFO; a pop in the same cycle lets a push into a full FIFO through.
module iec_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/iec_cmd_decoder.sv
// IEC command-layer decoder: tracks listener/talker addressing, strobes secondaries
// and buffers listener data bytes for the DOS side.
module iec_cmd_decoder
  import iec_pkg::*;
#(
  parameter logic [4:0] DEVICE_ADDR = 5'd8,
  parameter int         FIFO_DEPTH  = 16
) (
  input logic               clk,
  input logic               reset,
  iec_cmd_decoder_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  atn_state_e state_q;
  atn_state_e state_eff_s;
  logic       atn_q;
  logic       listening_q, talking_q, overflow_q;
  logic       open_q, close_q, data_q, talk_start_q;
  logic [3:0] sec_addr_q;

  logic       atn_rise_s, atn_fall_s, cmd_s, push_s, pop_s;
  logic       is_unlisten_s, is_untalk_s, is_listen_s, is_talk_s, own_addr_s;
  logic       is_primary_s, is_secondary_s, own_primary_s;
  logic       fifo_full_s, fifo_empty_s;
  logic [AW:0] fifo_count_s;
  logic [7:0] dout_s;

  assign atn_rise_s = bus.atn && !atn_q;
  assign atn_fall_s = !bus.atn && atn_q;
  assign cmd_s      = bus.rx_ready && bus.atn;
  assign push_s     = bus.rx_ready && !bus.atn && listening_q;
  assign pop_s      = bus.dout_ready && !fifo_empty_s;

  // UNLISTEN/UNTALK share the LISTEN/TALK top bits; address 31 is reserved for them.
  assign is_unlisten_s  = (bus.rx_byte == CMD_UNLISTEN);
  assign is_untalk_s    = (bus.rx_byte == CMD_UNTALK);
  assign is_listen_s    = (bus.rx_byte[7:5] == CMD_LISTEN) && !is_unlisten_s;
  assign is_talk_s      = (bus.rx_byte[7:5] == CMD_TALK) && !is_untalk_s;
  assign own_addr_s     = (bus.rx_byte[4:0] == DEVICE_ADDR);
  assign is_primary_s   = is_listen_s || is_talk_s || is_unlisten_s || is_untalk_s;
  assign own_primary_s  = (is_listen_s || is_talk_s) && own_addr_s;
  assign is_secondary_s = (bus.rx_byte[7:4] == SEC_DATA) || (bus.rx_byte[7:4] == SEC_CLOSE) ||
                          (bus.rx_byte[7:4] == SEC_OPEN);

  // ATN edge action, applied before the byte arriving in the same cycle
  always_comb begin
    state_eff_s = state_q;
    if (atn_rise_s) begin
      state_eff_s = A_PRIMARY;
    end else if (atn_fall_s) begin
      state_eff_s = A_IDLE;
    end else begin
      state_eff_s = state_q;
    end
  end

  // ATN-frame FSM with addressing flags and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= A_IDLE;
      atn_q        <= 1'b0;
      listening_q  <= 1'b0;
      talking_q    <= 1'b0;
      sec_addr_q   <= 4'h0;
      open_q       <= 1'b0;
      close_q      <= 1'b0;
      data_q       <= 1'b0;
      talk_start_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      atn_q        <= bus.atn;
      open_q       <= 1'b0;
      close_q      <= 1'b0;
      data_q       <= 1'b0;
      talk_start_q <= atn_fall_s && talking_q;
      state_q      <= state_eff_s;
      if (cmd_s) begin
        if (is_primary_s) begin
          if (is_listen_s && own_addr_s) begin
            listening_q <= 1'b1;
            talking_q   <= 1'b0;
          end else if (is_unlisten_s) begin
            listening_q <= 1'b0;
          end else if (is_talk_s && own_addr_s) begin
            talking_q   <= 1'b1;
            listening_q <= 1'b0;
          end else if (is_talk_s || is_untalk_s) begin
            talking_q <= 1'b0;
          end
          state_q <= own_primary_s ? A_SECONDARY : A_IGNORE;
        end else if ((state_eff_s == A_SECONDARY) && is_secondary_s) begin
          sec_addr_q <= bus.rx_byte[3:0];
          case (bus.rx_byte[7:4])
            SEC_DATA:  data_q  <= 1'b1;
            SEC_CLOSE: close_q <= 1'b1;
            SEC_OPEN:  open_q  <= 1'b1;
            default:   data_q  <= 1'b0;
          endcase
          state_q <= A_IGNORE;
        end else if ((state_eff_s == A_PRIMARY) || (state_eff_s == A_SECONDARY)) begin
          state_q <= A_IGNORE;
        end
      end
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  iec_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (bus.rx_byte),
    .rdata_o (dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign bus.listening   = listening_q;
  assign bus.talking     = talking_q;
  assign bus.sec_addr    = sec_addr_q;
  assign bus.open_pulse  = open_q;
  assign bus.close_pulse = close_q;
  assign bus.data_pulse  = data_q;
  assign bus.talk_start  = talk_start_q;
  assign bus.dout        = dout_s;
  assign bus.dout_valid  = (fifo_count_s != '0);
  assign bus.overflow    = overflow_q;

endmodule

// File: doc/iec_cmd_decoder.md
# iec_cmd_decoder

Downstream consumer of the IEC byte receiver: it takes each received byte plus the ATN line and decodes the IEC bus command layer: LISTEN/UNLISTEN, TALK/UNTALK, and the OPEN/CLOSE/DATA secondaries. It tracks whether this device is addressed as listener or talker and buffers listener data bytes in a small FIFO for the drive/DOS logic.

## Interface
- `DEVICE_ADDR`, default 8: 5-bit primary address of this device (0–30).
- `FIFO_DEPTH`, default 16: data FIFO entries, power of two, ≥2.
- `clk`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `atn`, in, 1: ATN asserted (1 = command phase); already synchronised and inverted to active-high.
- `rx_byte`, in, 8: received byte; valid only when `rx_ready` is high.
- `rx_ready`, in, 1: one-cycle strobe per received byte.
- `listening`, out, 1: device currently addressed as listener.
- `talking`, out, 1: device currently addressed as talker.
- `sec_addr`, out, 4: last accepted secondary address (channel).
- `open_pulse`, out, 1: one-cycle strobe on an accepted OPEN secondary.
- `close_pulse`, out, 1: one-cycle strobe on an accepted CLOSE secondary.
- `data_pulse`, out, 1: one-cycle strobe on an accepted DATA/reopen secondary.
- `talk_start`, out, 1: one-cycle strobe when ATN releases while `talking` is 1 (turnaround request to the transmitter).
- `dout`, out, 8: FIFO head byte.
- `dout_valid`, out, 1: FIFO not empty.
- `dout_ready`, in, 1: consumer pops the head when `dout_valid` and `dout_ready` are both 1.
- `overflow`, out, 1: sticky; a listener byte was dropped because the FIFO was full.

## Operation
Command decode applies when `rx_ready` is 1 and `atn` is 1. Byte classes:
- `0x20|a`: LISTEN. If `a == DEVICE_ADDR`, set `listening` and clear `talking`.
- `0x3F`: UNLISTEN. Clear `listening`.
- `0x40|a`: TALK. If `a == DEVICE_ADDR`, set `talking` and clear `listening`; otherwise clear `talking`.
- `0x5F`: UNTALK. Clear `talking`.
- `0x60|s`: DATA. `0xE0|s`: CLOSE. `0xF0|s`: OPEN. Here `s` is 4 bits.
- All other codes are ignored.

Secondary handling is governed by an ATN-frame FSM:
- States: `A_IDLE`, `A_PRIMARY`, `A_SECONDARY`, `A_IGNORE`.
- `A_IDLE` → `A_PRIMARY` on `atn` rising.
- `A_PRIMARY`, on a primary LISTEN/TALK to own address → `A_SECONDARY`.
- `A_PRIMARY`, on any other byte → `A_IGNORE`, after applying the UNLISTEN/UNTALK/other-TALK effects listed above.
- `A_SECONDARY`, on a secondary byte: latch `sec_addr`, pulse the matching strobe, → `A_IGNORE`.
- `A_SECONDARY`, on a further primary: decode it as a primary; state follows the `A_PRIMARY` rules.
- Any state → `A_IDLE` on `atn` falling. If `talking` is 1 at that point, pulse `talk_start`.
- A secondary received outside `A_SECONDARY` is ignored and produces no strobe.

Data path:
- When `rx_ready` is 1, `atn` is 0 and `listening` is 1, push `rx_byte` into the FIFO.
- When `atn` is 0 and `listening` is 0, the byte is discarded.
- A push while full is dropped and sets `overflow`. Exception: a pop in the same cycle frees a slot, so the push is accepted.
- Push and pop in the same cycle on a non-empty FIFO keep the occupancy unchanged.
- UNLISTEN does not flush the FIFO.

## Timing
- Reset state: `listening`, `talking`, all pulses, `dout_valid` and `overflow` are 0. `sec_addr` and `dout` are 0. FSM is in `A_IDLE`. FIFO pointers are 0.
- Reset mid-frame or mid-FIFO discards everything.
- All outputs are registered. A strobe at cycle N produces updated flags or pulses at cycle N+1.
- A byte pushed at cycle N into an empty FIFO is visible as `dout_valid` = 1 at N+1.
- Pop is combinational-accept. `dout` presents the next entry on the following cycle.
- An `atn` edge and `rx_ready` in the same cycle: the byte is classified using the new `atn` value. The FSM edge action is applied first, then the byte.
- `talk_start` asserts the cycle after `atn` falls.

## Structure
- Shared package `iec_pkg` holds:
  - command code constants: `CMD_LISTEN = 3'b001`, `CMD_TALK = 3'b010` (top bits), `CMD_UNLISTEN = 8'h3F`, `CMD_UNTALK = 8'h5F`, `SEC_DATA = 4'h6`, `SEC_CLOSE = 4'hE`, `SEC_OPEN = 4'hF`;
  - the ATN FSM state enum.
- The FIFO is a sub-module `iec_sync_fifo`, parameterised by width and depth, with full, empty and count outputs.

## Test plan
- ATN high, bytes `0x28`, `0xF2`; then ATN low → `listening` = 1, `open_pulse` for one cycle, `sec_addr` = 2, `talk_start` stays 0.
- ATN low, `listening` = 1, bytes `0x41`, `0x42`, `0x43`; consumer holds `dout_ready` = 0 → `dout_valid` = 1 with `dout` = `0x41`. Then with `dout_ready` = 1, `dout` reads `0x41`, `0x42`, `0x43` in order, then `dout_valid` = 0.
- ATN high, bytes `0x48`, `0x60`; then ATN low → `talking` = 1, `data_pulse` fires, `talk_start` pulses one cycle after the ATN fall.
- ATN high, bytes `0x29`, `0xE3` (other device) → no strobes, `sec_addr` unchanged, `listening` unchanged.
- Listener receives 17 bytes with no pops (depth 16) → first 16 are retained, `overflow` = 1. With `dout_ready` held 1 at full and a push in the same cycle → no overflow.
- Assert `reset` while listening with 5 bytes buffered → next cycle all flags are 0 and `dout_valid` = 0.
